// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared widths and status-LED bit positions for the front panel.
// Revision    : 1.0  initial release
// ============================================================================
package io_pkg;

    localparam int c_IN_W    = 5;
    localparam int c_OUT_W   = 32;
    localparam int c_DIGITS  = 8;
    localparam int c_AN_W    = $clog2(c_DIGITS);
    localparam int c_NIB_W   = 4;

    localparam int c_LED_OVR = 7;
    localparam int c_LED_RDY = 6;
    localparam int c_LED_RUN = 5;

    // Hex digit 'idx' of a display word, digit 0 being the least significant.
    function automatic logic [c_NIB_W-1:0] nibble_sel(
        input logic [c_OUT_W-1:0] word,
        input logic [c_AN_W-1:0]  idx
    );
        return word[int'(idx)*c_NIB_W +: c_NIB_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_io_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronises a bouncing button, filters it and emits a
//               one-cycle pulse on each accepted press.
// Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_button,
    output logic o_step_pulse
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_db;
    logic        r_pulse;
    logic [15:0] r_cnt;

    logic        w_differs;
    logic        w_settled;

    assign w_differs    = (r_sync2 != r_db);
    // The new level is taken on the DEB_CYCLES-th consecutive differing cycle.
    assign w_settled    = w_differs && (r_cnt == DEB_CYCLES - 16'd1);
    assign o_step_pulse = r_pulse;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            r_pulse <= w_settled & r_sync2;
            if (!w_differs || w_settled) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_settled) begin
                r_db <= r_sync2;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_io_ctrl
// Description : Front-panel controller: step/run clock enable, switch input
//               handshake, output latch and multiplexed hex display.
// Revision    : 1.0  initial release
// ============================================================================
module cpu_io_ctrl
    import io_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [15:0] SCAN_DIV   = 16'd10000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               button,
    input  logic               run,
    input  logic               valid,
    input  logic [c_IN_W-1:0]  in_sw,
    input  logic               cpu_rd_in,
    input  logic               cpu_wr_out,
    input  logic [c_OUT_W-1:0] cpu_out_data,
    output logic               cpu_en,
    output logic [c_OUT_W-1:0] in_data,
    output logic               in_ready,
    output logic [c_AN_W-1:0]  an,
    output logic [c_NIB_W-1:0] seg,
    output logic [7:0]         led
);

    localparam int c_PAD = c_OUT_W - c_IN_W;

    logic               r_run1;
    logic               r_run_s;
    logic               r_val1;
    logic               r_val_s;
    logic               r_val_q;
    logic [c_IN_W-1:0]  r_sw1;
    logic [c_IN_W-1:0]  r_sw_s;
    logic               r_cpu_en;
    logic [c_IN_W-1:0]  r_buf;
    logic               r_rdy;
    logic               r_ovr;
    logic [c_OUT_W-1:0] r_out;
    logic [15:0]        r_scan;
    logic [c_AN_W-1:0]  r_an;
    logic [c_NIB_W-1:0] r_seg;

    logic               w_step;
    logic               w_val_rise;
    logic               w_consume;
    logic               w_wr;
    logic               w_scan_wrap;
    logic [c_AN_W-1:0]  w_an_nxt;

    btn_debounce #(
        .DEB_CYCLES   (DEB_CYCLES)
    ) u_btn_debounce (
        .clk          (clk),
        .rstn         (rstn),
        .i_button     (button),
        .o_step_pulse (w_step)
    );

    always_comb begin
        w_val_rise  = r_val_s & ~r_val_q;
        w_consume   = cpu_rd_in & r_cpu_en & r_rdy;
        w_wr        = cpu_wr_out & r_cpu_en;
        w_scan_wrap = (r_scan == SCAN_DIV - 16'd1);
        w_an_nxt    = w_scan_wrap ? r_an + 1'b1 : r_an;
    end

    // Synchronisers and clock enable
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run1   <= 1'b0;
            r_run_s  <= 1'b0;
            r_val1   <= 1'b0;
            r_val_s  <= 1'b0;
            r_val_q  <= 1'b0;
            r_sw1    <= '0;
            r_sw_s   <= '0;
            r_cpu_en <= 1'b0;
        end else begin
            r_run1   <= run;
            r_run_s  <= r_run1;
            r_val1   <= valid;
            r_val_s  <= r_val1;
            r_val_q  <= r_val_s;
            r_sw1    <= in_sw;
            r_sw_s   <= r_sw1;
            r_cpu_en <= r_run_s | w_step;
        end
    end

    // Input buffer: a consume in the same cycle as a new offer frees the slot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf <= '0;
            r_rdy <= 1'b0;
            r_ovr <= 1'b0;
        end else if (w_val_rise) begin
            if (!r_rdy || w_consume) begin
                r_buf <= r_sw_s;
                r_rdy <= 1'b1;
            end else begin
                r_ovr <= 1'b1;
            end
        end else if (w_consume) begin
            r_rdy <= 1'b0;
        end
    end

    // Output latch and display scan; seg is reloaded alongside an
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out  <= '0;
            r_scan <= '0;
            r_an   <= '0;
            r_seg  <= '0;
        end else begin
            if (w_wr) begin
                r_out <= cpu_out_data;
            end
            r_scan <= w_scan_wrap ? 16'd0 : r_scan + 16'd1;
            r_an   <= w_an_nxt;
            r_seg  <= nibble_sel(r_out, w_an_nxt);
        end
    end

    assign cpu_en                = r_cpu_en;
    assign in_data               = {{c_PAD{1'b0}}, r_buf};
    assign in_ready              = r_rdy;
    assign an                    = r_an;
    assign seg                   = r_seg;
    assign led[c_LED_OVR]        = r_ovr;
    assign led[c_LED_RDY]        = r_rdy;
    assign led[c_LED_RUN]        = r_run_s;
    assign led[c_IN_W-1:0]       = r_buf;

endmodule
`default_nettype wire

// File: doc/cpu_io_ctrl.md
Name: cpu_io_ctrl

Overview:
Front-panel controller between the board I/O (button, switches, 7-seg, LEDs) and the lab CPU core. It debounces the step button, generates the CPU clock-enable for single-step or free-run, and runs a valid/consume handshake for the 5-bit switch input port. It also latches the CPU output port and time-multiplexes it onto the 8-digit hex display.

Parameters:
DEB_CYCLES, 16'd50000, cycles the button must be stable before a level change is accepted (bench uses 4)
SCAN_DIV, 16'd10000, clk cycles per display digit (bench uses 2)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
button  in  1  raw step button, asynchronous, bouncing
run  in  1  switch: 1 = free-run, 0 = single-step; asynchronous
valid  in  1  switch: rising edge offers in_sw to CPU; asynchronous
in_sw  in  5  switch input data, sampled only on valid rising edge
cpu_rd_in  in  1  CPU reads input port this enabled cycle
cpu_wr_out  in  1  CPU writes output port this enabled cycle
cpu_out_data  in  32  CPU output port data
cpu_en  out  1  clock-enable for every CPU state element
in_data  out  32  zero-extended in_buf, to CPU read mux
in_ready  out  1  in_buf holds unconsumed data
an  out  3  display digit select 0..7
seg  out  4  hex nibble for selected digit
led  out  8  status: {ovr, in_ready, run_s, in_buf[4:0]}

Behaviour:
- Reset (rstn low, async): cpu_en=0, in_buf=0, in_ready=0, ovr=0, out_reg=0, an=0, seg=0, led=0, debounce counter=0, all sync flops=0, scan counter=0.
- Sync: button, run, valid each pass a 2-flop synchronizer -> btn_s, run_s, val_s; val_s edge detector uses a third flop.
- Debounce: btn_db changes only after btn_s differs from btn_db for DEB_CYCLES consecutive cycles; any match resets the counter. step_pulse = one-cycle pulse on btn_db 0->1 only.
- cpu_en: run_s=1 -> 1 every cycle (step presses ignored); run_s=0 -> equals step_pulse. Registered: cpu_en rises the cycle after step_pulse. run_s falling mid-run stops cpu_en the next cycle.
- Input handshake: val_rise = val_s & ~val_q.
  - val_rise & ~in_ready: in_buf<=in_sw (synced value), in_ready<=1.
  - val_rise & in_ready & ~consume: no data change, ovr<=1 (sticky until reset).
  - consume = cpu_rd_in & cpu_en & in_ready: in_ready<=0.
  - consume & val_rise same cycle: in_buf<=new data, in_ready stays 1, no ovr.
  - cpu_rd_in while ~in_ready: in_data returns last in_buf, no state change.
  - in_data = {27'b0, in_buf}, combinational from register.
- Output: cpu_wr_out & cpu_en -> out_reg<=cpu_out_data; visible on display next scan slot.
- Display scan: counter 0..SCAN_DIV-1; at wrap an<=an+1 (7 wraps to 0). seg = out_reg[4*an+3 : 4*an], registered with an.
- cpu_rd_in/cpu_wr_out ignored when cpu_en=0.

Decomposition:
- Shared package io_pkg: IN_W=5, OUT_W=32, DIGITS=8, LED field bit positions.
- One sub-module: btn_debounce (sync + counter + edge pulse), parameterised by DEB_CYCLES; cpu_io_ctrl instantiates it once for button.

Test Plan:
- Reset: rstn=0 after random activity -> all outputs 0 immediately (async), hold until rstn=1.
- Debounce (DEB_CYCLES=4, run=0): button bounces 1,0,1 at 1-cycle spacing then holds 1 for 10 cycles -> exactly one cpu_en pulse, 1 cycle wide; release with bounce -> no pulse.
- Free-run: run=1 -> cpu_en=1 continuously after sync latency; button presses cause no change; run=0 -> cpu_en=0 within 3 cycles.
- Handshake: in_sw=5'h01, valid 0->1 -> in_ready=1, in_data=32'h1, led=8'h41 (run=0); step with cpu_rd_in=1 -> in_ready=0; valid 1->0->1 with in_sw=5'h02 -> in_data=32'h2.
- Overrun and same-cycle: second valid edge with in_sw=5'h03 while in_ready=1 -> in_data stays 32'h2, led[7]=1; with run=1, cpu_rd_in=1 aligned to val_rise carrying 5'h04 -> in_ready stays 1, in_data=32'h4, ovr unchanged.
- Display (SCAN_DIV=2): cpu_wr_out=1, cpu_out_data=32'h1234ABCD, cpu_en=1 -> an steps 0..7 every 2 cycles, seg=D,C,B,A,4,3,2,1, then an wraps to 0.
